// File: rtl/mem_req_arbiter_if.sv
// Bus bundle between the requesting channels, the arbiter and the memory controller.
// Handshake: a channel raises req_ren/req_wen and holds it (with addr/wdata) until its
// req_hit pulse; mem_ren/mem_wen are held with addr/wdata stable until mem_hit is seen.
interface mem_req_arbiter_if #(
   parameter int NCH = 2,
   parameter int AW  = 32,
   parameter int DW  = 32
);
   localparam int GW = $clog2(NCH);

   logic [NCH-1:0]    req_ren;
   logic [NCH-1:0]    req_wen;
   logic [NCH*AW-1:0] req_addr;
   logic [NCH*DW-1:0] req_wdata;
   logic [NCH-1:0]    req_hit;
   logic [DW-1:0]     req_rdata;
   logic              halt;
   logic              mem_ren;
   logic              mem_wen;
   logic [AW-1:0]     mem_addr;
   logic [DW-1:0]     mem_wdata;
   logic              mem_hit;
   logic [DW-1:0]     mem_rdata;
   logic              busy;
   logic [GW-1:0]     grant_id;

   modport slave (
      input  req_ren, req_wen, req_addr, req_wdata, halt, mem_hit, mem_rdata,
      output req_hit, req_rdata, mem_ren, mem_wen, mem_addr, mem_wdata, busy, grant_id
   );

   modport master (
      output req_ren, req_wen, req_addr, req_wdata, halt, mem_hit, mem_rdata,
      input  req_hit, req_rdata, mem_ren, mem_wen, mem_addr, mem_wdata, busy, grant_id
   );
endinterface

// File: rtl/mem_req_arbiter.sv
// Arbitrates NCH request channels onto one memory port; the granted request is
// registered and held until mem_hit, which is forwarded as a per-channel hit pulse.
module mem_req_arbiter #(
   parameter int NCH = 2,
   parameter int AW  = 32,
   parameter int DW  = 32,
   parameter int RR  = 1
) (
   input  logic             CLK,
   input  logic             nRST,
   mem_req_arbiter_if.slave bus_io,
   output logic             dbg_state_o
);
   localparam int GW = $clog2(NCH);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t          state_q;
   logic [GW-1:0]   ptr_q;
   logic [GW-1:0]   grant_q;
   logic            ren_q;
   logic            wen_q;
   logic [AW-1:0]   addr_q;
   logic [DW-1:0]   wdata_q;

   logic [NCH-1:0]   active;
   logic [2*NCH-1:0] dbl;
   logic [NCH-1:0]   rot;
   logic [GW:0]      ptr_p1;
   logic [GW:0]      wsum;
   logic [GW-1:0]    win_off;
   logic             found_d;
   logic [GW-1:0]    grant_d;
   logic [AW-1:0]    addr_d;
   logic [DW-1:0]    wdata_d;
   logic             sel_ren;
   logic             sel_wen;

   // Rotate the active vector so the search always starts at bit 0 (ptr+1 for RR).
   always_comb begin
      active  = bus_io.req_ren | bus_io.req_wen;
      dbl     = {active, active};
      ptr_p1  = {1'b0, ptr_q} + {{GW{1'b0}}, 1'b1};
      rot     = active;
      found_d = 1'b0;
      win_off = '0;
      wsum    = '0;
      grant_d = '0;
      if (RR != 0) begin
         rot = NCH'(dbl >> ptr_p1);
      end
      for (int j = NCH - 1; j >= 0; j--) begin
         if (rot[j]) begin
            found_d = 1'b1;
            win_off = GW'(j);
         end
      end
      if (RR != 0) begin
         wsum = ptr_p1 + {1'b0, win_off};
         if (wsum >= (GW+1)'(NCH)) begin
            wsum = wsum - (GW+1)'(NCH);
         end
         grant_d = wsum[GW-1:0];
      end else begin
         grant_d = win_off;
      end
   end

   always_comb begin
      addr_d  = '0;
      wdata_d = '0;
      sel_ren = 1'b0;
      sel_wen = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         if (grant_d == GW'(i)) begin
            addr_d  = bus_io.req_addr[i*AW +: AW];
            wdata_d = bus_io.req_wdata[i*DW +: DW];
            sel_ren = bus_io.req_ren[i];
            sel_wen = bus_io.req_wen[i];
         end
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= IDLE;
         ptr_q   <= GW'(NCH - 1);
         grant_q <= '0;
         ren_q   <= 1'b0;
         wen_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (!bus_io.halt && found_d) begin
                  grant_q <= grant_d;
                  addr_q  <= addr_d;
                  wdata_q <= wdata_d;
                  // A channel asking for both read and write is served as a write.
                  wen_q   <= sel_wen;
                  ren_q   <= sel_ren & ~sel_wen;
                  state_q <= BUSY;
               end
            end
            BUSY: begin
               if (bus_io.mem_hit) begin
                  ren_q   <= 1'b0;
                  wen_q   <= 1'b0;
                  ptr_q   <= grant_q;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus_io.mem_ren   = ren_q;
   assign bus_io.mem_wen   = wen_q;
   assign bus_io.mem_addr  = addr_q;
   assign bus_io.mem_wdata = wdata_q;
   assign bus_io.busy      = (state_q == BUSY);
   assign bus_io.grant_id  = grant_q;
   assign bus_io.req_hit   = ((state_q == BUSY) && bus_io.mem_hit) ?
                             ({{(NCH-1){1'b0}}, 1'b1} << grant_q) : '0;
   assign bus_io.req_rdata = bus_io.mem_rdata;
   assign dbg_state_o      = state_q;
endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench: a round-robin and a fixed-priority arbiter share the same stimulus;
// expected grants and hits are queued at issue time and popped by a negedge monitor.
module tb_mem_req_arbiter;
  localparam int NCH = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int GW  = 2;
  localparam int GNT_W = GW + 2 + AW + DW;
  localparam int HIT_W = 1 + NCH + DW;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  logic [NCH-1:0]    req_ren = '0;
  logic [NCH-1:0]    req_wen = '0;
  logic [NCH*AW-1:0] req_addr = '0;
  logic [NCH*DW-1:0] req_wdata = '0;
  logic              halt = 1'b0;
  logic              mem_hit = 1'b0;
  logic [DW-1:0]     mem_rdata = '0;
  logic              dbg_a;
  logic              dbg_b;
  logic              chk_fp = 1'b0;

  int total = 0;
  int bad = 0;

  logic [GNT_W-1:0] gnt_q[$];
  logic [HIT_W-1:0] hit_q[$];
  logic [GW-1:0]    fp_q[$];

  mem_req_arbiter_if #(.NCH(NCH), .AW(AW), .DW(DW)) ifa ();
  mem_req_arbiter_if #(.NCH(NCH), .AW(AW), .DW(DW)) ifb ();

  assign ifa.req_ren = req_ren;     assign ifb.req_ren = req_ren;
  assign ifa.req_wen = req_wen;     assign ifb.req_wen = req_wen;
  assign ifa.req_addr = req_addr;   assign ifb.req_addr = req_addr;
  assign ifa.req_wdata = req_wdata; assign ifb.req_wdata = req_wdata;
  assign ifa.halt = halt;           assign ifb.halt = halt;
  assign ifa.mem_hit = mem_hit;     assign ifb.mem_hit = mem_hit;
  assign ifa.mem_rdata = mem_rdata; assign ifb.mem_rdata = mem_rdata;

  mem_req_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .RR(1)) dut_rr (
    .CLK(CLK), .nRST(nRST), .bus_io(ifa), .dbg_state_o(dbg_a)
  );
  mem_req_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .RR(0)) dut_fp (
    .CLK(CLK), .nRST(nRST), .bus_io(ifb), .dbg_state_o(dbg_b)
  );

  // clock / watchdog
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    bad = bad + 1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_gnt(input logic [GW-1:0] g, input logic w, input logic r,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    gnt_q.push_back({g, w, r, a, d});
  endtask

  task automatic wait_busy(input int budget);
    int n = 0;
    while (!ifa.busy && n < budget) begin
      tick();
      n++;
    end
    chk("wait_busy", {127'd0, ifa.busy}, 128'd1);
  endtask

  task automatic hit_after(input int n, input logic [NCH-1:0] hv, input logic [DW-1:0] rd,
                           input logic chk_rd);
    repeat (n) tick();
    mem_hit = 1'b1;
    mem_rdata = rd;
    hit_q.push_back({chk_rd, hv, rd});
    tick();
    mem_hit = 1'b0;
  endtask

  // monitor / scoreboard
  logic prev_en_a = 1'b0;
  logic prev_en_b = 1'b0;
  always @(negedge CLK) begin
    logic en_a;
    logic en_b;
    logic [GNT_W-1:0] eg;
    logic [HIT_W-1:0] eh;
    logic [GW-1:0] ef;
    en_a = ifa.mem_ren | ifa.mem_wen;
    en_b = ifb.mem_ren | ifb.mem_wen;
    if (en_a && !prev_en_a) begin
      if (gnt_q.size() == 0) begin
        chk("grant_unexpected", {127'd0, 1'b1}, 128'd0);
      end else begin
        eg = gnt_q.pop_front();
        chk("grant", 128'({ifa.grant_id, ifa.mem_wen, ifa.mem_ren, ifa.mem_addr, ifa.mem_wdata}),
            128'(eg));
      end
    end
    if (ifa.req_hit != '0) begin
      if (hit_q.size() == 0) begin
        chk("hit_unexpected", 128'(ifa.req_hit), 128'd0);
      end else begin
        eh = hit_q.pop_front();
        if (eh[HIT_W-1])
          chk("hit_rd", 128'({ifa.req_hit, ifa.req_rdata}), 128'(eh[NCH+DW-1:0]));
        else
          chk("hit_wr", 128'(ifa.req_hit), 128'(eh[NCH+DW-1:DW]));
      end
    end
    if (chk_fp && en_b && !prev_en_b) begin
      if (fp_q.size() == 0) begin
        chk("fp_grant_unexpected", 128'(ifb.grant_id), 128'hFF);
      end else begin
        ef = fp_q.pop_front();
        chk("fp_grant", 128'(ifb.grant_id), 128'(ef));
      end
    end
    prev_en_a = en_a;
    prev_en_b = en_b;
  end

  // stimulus
  initial begin
    // reset with ch1 requesting
    req_ren[1] = 1'b1;
    req_addr[1*AW +: AW] = 32'h200;
    repeat (2) tick();
    chk("rst_ren", 128'(ifa.mem_ren), 128'd0);
    chk("rst_wen", 128'(ifa.mem_wen), 128'd0);
    chk("rst_addr", 128'(ifa.mem_addr), 128'd0);
    chk("rst_wdata", 128'(ifa.mem_wdata), 128'd0);
    chk("rst_busy", 128'(ifa.busy), 128'd0);
    chk("rst_grant", 128'(ifa.grant_id), 128'd0);
    chk("rst_hit", 128'(ifa.req_hit), 128'd0);
    push_gnt(2'd1, 1'b0, 1'b1, 32'h200, 32'h0);
    nRST = 1'b1;
    tick();
    chk("rel_ren", 128'(ifa.mem_ren), 128'd1);
    chk("rel_grant", 128'(ifa.grant_id), 128'd1);
    hit_after(0, 4'b0010, 32'h1111_2222, 1'b1);
    req_ren = '0;

    // single read on ch0, hit after 3 busy cycles
    req_ren[0] = 1'b1;
    req_addr[0*AW +: AW] = 32'h100;
    push_gnt(2'd0, 1'b0, 1'b1, 32'h100, 32'h0);
    wait_busy(8);
    hit_after(3, 4'b0001, 32'hDEAD_BEEF, 1'b1);
    req_ren = '0;
    chk("rd_ren_low", 128'(ifa.mem_ren), 128'd0);
    chk("rd_hit_low", 128'(ifa.req_hit), 128'd0);
    chk("rd_addr_hold", 128'(ifa.mem_addr), 128'h100);

    // round-robin vs fixed priority with ch0, ch2, ch3 held
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    req_addr[0*AW +: AW] = 32'h300;
    req_addr[2*AW +: AW] = 32'h320;
    req_addr[3*AW +: AW] = 32'h330;
    for (int k = 0; k < 2; k++) begin
      push_gnt(2'd0, 1'b0, 1'b1, 32'h300, 32'h0);
      push_gnt(2'd2, 1'b0, 1'b1, 32'h320, 32'h0);
      push_gnt(2'd3, 1'b0, 1'b1, 32'h330, 32'h0);
      hit_q.push_back({1'b1, 4'b0001, 32'hA5A5_0000});
      hit_q.push_back({1'b1, 4'b0100, 32'hA5A5_0000});
      hit_q.push_back({1'b1, 4'b1000, 32'hA5A5_0000});
    end
    for (int k = 0; k < 6; k++) fp_q.push_back(2'd0);
    chk_fp = 1'b1;
    mem_rdata = 32'hA5A5_0000;
    mem_hit = 1'b1;
    req_ren = 4'b1101;
    repeat (12) tick();
    req_ren = '0;
    mem_hit = 1'b0;
    chk_fp = 1'b0;
    tick();

    // read+write collision on ch1: write wins
    req_ren[1] = 1'b1;
    req_wen[1] = 1'b1;
    req_addr[1*AW +: AW] = 32'h400;
    req_wdata[1*DW +: DW] = 32'h55;
    push_gnt(2'd1, 1'b1, 1'b0, 32'h400, 32'h55);
    wait_busy(8);
    chk("col_ren", 128'(ifa.mem_ren), 128'd0);
    hit_after(1, 4'b0010, 32'h0, 1'b0);
    req_ren = '0;
    req_wen = '0;
    req_wdata[1*DW +: DW] = 32'h0;

    // halt while ch0 busy and ch1 pending
    req_addr[0*AW +: AW] = 32'h500;
    req_addr[1*AW +: AW] = 32'h600;
    push_gnt(2'd0, 1'b0, 1'b1, 32'h500, 32'h0);
    req_ren = 4'b0011;
    wait_busy(8);
    halt = 1'b1;
    hit_after(1, 4'b0001, 32'hCAFE_0001, 1'b1);
    req_ren[0] = 1'b0;
    repeat (3) begin
      tick();
      chk("halt_busy", 128'(ifa.busy), 128'd0);
      chk("halt_ren", 128'(ifa.mem_ren), 128'd0);
    end
    push_gnt(2'd1, 1'b0, 1'b1, 32'h600, 32'h0);
    halt = 1'b0;
    tick();
    chk("unhalt_ren", 128'(ifa.mem_ren), 128'd1);
    chk("unhalt_grant", 128'(ifa.grant_id), 128'd1);
    hit_after(0, 4'b0010, 32'hCAFE_0002, 1'b1);
    req_ren = '0;

    // reset mid-transaction, then spurious hit in IDLE
    req_ren[2] = 1'b1;
    req_addr[2*AW +: AW] = 32'h700;
    push_gnt(2'd2, 1'b0, 1'b1, 32'h700, 32'h0);
    wait_busy(8);
    tick();
    nRST = 1'b0;
    #1;
    chk("mid_rst_ren", 128'(ifa.mem_ren), 128'd0);
    chk("mid_rst_busy", 128'(ifa.busy), 128'd0);
    mem_hit = 1'b1;
    #1;
    chk("mid_rst_hit", 128'(ifa.req_hit), 128'd0);
    mem_hit = 1'b0;
    req_ren = '0;
    tick();
    nRST = 1'b1;
    tick();
    mem_hit = 1'b1;
    mem_rdata = 32'h1234_5678;
    #1;
    chk("idle_hit", 128'(ifa.req_hit), 128'd0);
    tick();
    chk("idle_hit_busy", 128'(ifa.busy), 128'd0);
    mem_hit = 1'b0;
    repeat (2) tick();

    // final report
    chk("gnt_q_empty", 128'(gnt_q.size()), 128'd0);
    chk("hit_q_empty", 128'(hit_q.size()), 128'd0);
    chk("fp_q_empty", 128'(fp_q.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
